// File: rtl/seq_detect_sched.sv
// Shares one serial 1101-style sequence detector among NREQ requesters: grant, clear, scan MSB-first, report match count.
// SEQ_SCHED_RR_EN selects round-robin arbitration; when undefined, fixed lowest-index priority is built.
module seq_detect_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int CNT_W = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  det_bit,
  output logic                  det_reset,
  input  logic                  det_flag,
  output logic                  res_valid,
  output logic [ID_W-1:0]       res_id,
  output logic [CNT_W-1:0]      res_count,
  input  logic                  res_ready
);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, REPORT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [BW-1:0]    bitcnt, bitcnt_nxt;
  logic [NREQ-1:0]  gnt_nxt;
  logic             det_bit_nxt, det_reset_nxt, res_valid_nxt;
  logic [ID_W-1:0]  res_id_nxt;
  logic [CNT_W-1:0] res_count_nxt, cnt_inc;
  logic [ID_W-1:0]  win;
  logic             any;

`ifdef SEQ_SCHED_RR_EN
  logic [ID_W-1:0] ptr, ptr_nxt;

  // Search begins one past the last winner and wraps modulo NREQ.
  always_comb begin : arb
    int idx;
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req[idx]) begin
        any = 1'b1;
        win = ID_W'(idx);
      end
    end
  end
`else
  always_comb begin : arb
    win = '0;
    any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        win = ID_W'(i);
      end
    end
  end
`endif

  assign cnt_inc = (det_flag && (res_count != {CNT_W{1'b1}})) ? res_count + CNT_W'(1) : res_count;

  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    bitcnt_nxt    = bitcnt;
    gnt_nxt       = '0;
    det_bit_nxt   = det_bit;
    det_reset_nxt = det_reset;
    res_valid_nxt = res_valid;
    res_id_nxt    = res_id;
    res_count_nxt = res_count;
`ifdef SEQ_SCHED_RR_EN
    ptr_nxt       = ptr;
`endif
    case (state)
      IDLE: begin
        det_reset_nxt = 1'b1;
        det_bit_nxt   = 1'b0;
        if (any) begin
          gnt_nxt       = NREQ'(1) << win;
          shreg_nxt     = req_data[win*WIDTH +: WIDTH];
          res_id_nxt    = win;
          res_count_nxt = '0;
          det_reset_nxt = 1'b0;
          state_nxt     = CLEAR;
`ifdef SEQ_SCHED_RR_EN
          ptr_nxt       = win;
`endif
        end
      end
      CLEAR: begin
        det_reset_nxt = 1'b1;
        det_bit_nxt   = shreg[WIDTH-1];
        bitcnt_nxt    = BW'(WIDTH - 1);
        state_nxt     = SHIFT;
      end
      SHIFT: begin
        res_count_nxt = cnt_inc;
        if (bitcnt == '0) begin
          det_bit_nxt = 1'b0;
          state_nxt   = DRAIN;
        end else begin
          bitcnt_nxt  = bitcnt - BW'(1);
          shreg_nxt   = shreg << 1;
          det_bit_nxt = shreg[WIDTH-2];
        end
      end
      // Flag raised by the final bit only appears one cycle later.
      DRAIN: begin
        res_count_nxt = cnt_inc;
        res_valid_nxt = 1'b1;
        state_nxt     = REPORT;
      end
      REPORT: begin
        if (res_ready) begin
          res_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      gnt       <= '0;
      det_bit   <= 1'b0;
      det_reset <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_count <= '0;
`ifdef SEQ_SCHED_RR_EN
      ptr       <= '0;
`endif
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bitcnt    <= bitcnt_nxt;
      gnt       <= gnt_nxt;
      det_bit   <= det_bit_nxt;
      det_reset <= det_reset_nxt;
      res_valid <= res_valid_nxt;
      res_id    <= res_id_nxt;
      res_count <= res_count_nxt;
`ifdef SEQ_SCHED_RR_EN
      ptr       <= ptr_nxt;
`endif
    end
  end
endmodule
